// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the Avalon-MM host arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, CMD, RDWAIT)
//   RESP_OKAY    : Avalon response code for a good transfer
//   RESP_SLVERR  : Avalon response code returned on a read timeout
package avalon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder.
// Ports:
//   req   in  N          request vector, one bit per requester
//   last  in  $clog2(N)  index granted most recently
//   grant out $clog2(N)  index of the winner (0 when valid is low)
//   valid out 1          at least one requester present
// The search starts at last+1 and wraps at N-1 to 0, so the previous winner is
// considered last.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          valid
);

    int unsigned idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (32'(last) + 32'(k)) % 32'(N);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/avalon_mm_host_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave port between NUM_HOSTS hosts,
// one outstanding transaction at a time.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   h_addr/h_read/h_write/h_writedata/h_byteenable
//                         packed per-host command, host i at slice i
//   h_waitrequest         per-host waitrequest (only the granted host in CMD
//                         ever sees it low)
//   h_readdatavalid       per-host, registered one-cycle read-data strobe
//   h_readdata/h_response shared read return, valid with h_readdatavalid
//   m_*                   downstream command / response
//   err_timeout           one-cycle pulse when a read times out
// Optional feature: define ARB_TIMEOUT_EN to abort reads that get no
// m_readdatavalid within TIMEOUT_CYCLES cycles of RDWAIT; the host then receives
// SLVERR with zero data. Without it RDWAIT waits forever and err_timeout is 0.
module avalon_mm_host_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int NUM_HOSTS      = 2,
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_HOSTS*ADDR_WIDTH-1:0]     h_addr,
    input  logic [NUM_HOSTS-1:0]                h_read,
    input  logic [NUM_HOSTS-1:0]                h_write,
    input  logic [NUM_HOSTS*DATA_WIDTH-1:0]     h_writedata,
    input  logic [NUM_HOSTS*(DATA_WIDTH/8)-1:0] h_byteenable,
    output logic [NUM_HOSTS-1:0]                h_waitrequest,
    output logic [NUM_HOSTS-1:0]                h_readdatavalid,
    output logic [DATA_WIDTH-1:0]               h_readdata,
    output logic [1:0]                          h_response,
    output logic [ADDR_WIDTH-1:0]               m_addr,
    output logic                                m_read,
    output logic                                m_write,
    output logic [DATA_WIDTH-1:0]               m_writedata,
    output logic [DATA_WIDTH/8-1:0]             m_byteenable,
    input  logic                                m_waitrequest,
    input  logic                                m_readdatavalid,
    input  logic [DATA_WIDTH-1:0]               m_readdata,
    input  logic [1:0]                          m_response,
    output logic                                err_timeout
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int GW       = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
    localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);

`ifdef ARB_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    arb_state_t        state;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     last_grant;
    logic [CNT_W-1:0]  tmo_cnt;

    logic [GW-1:0]     arb_grant;
    logic              arb_valid;
    logic              host_rd;
    logic              host_wr;
    logic              tmo_fire;
    int unsigned       gidx;

    rr_arbiter #(
        .N  (NUM_HOSTS),
        .IW (GW)
    ) u_rr_arbiter (
        .req   (h_read | h_write),
        .last  (last_grant),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign gidx    = 32'(grant);
    assign host_rd = h_read[grant];
    assign host_wr = h_write[grant];
    // Constant-folds away when the timeout feature is not built in.
    assign tmo_fire = TMO_EN && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Downstream command is a live mux of the granted host, only in CMD.
    always_comb begin
        m_addr        = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = '0;
        m_byteenable  = '0;
        h_waitrequest = '1;
        if (state == CMD) begin
            m_addr       = h_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
            m_writedata  = h_writedata[gidx*DATA_WIDTH +: DATA_WIDTH];
            m_byteenable = h_byteenable[gidx*BE_WIDTH +: BE_WIDTH];
            // Read+write together is illegal; the write takes precedence.
            m_write      = host_wr;
            m_read       = host_rd & ~host_wr;
            h_waitrequest[grant] = m_waitrequest;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            grant           <= '0;
            last_grant      <= GW'(NUM_HOSTS - 1);
            tmo_cnt         <= '0;
            h_readdatavalid <= '0;
            h_readdata      <= '0;
            h_response      <= RESP_OKAY;
            err_timeout     <= 1'b0;
        end else begin
            h_readdatavalid <= '0;
            err_timeout     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant      <= arb_grant;
                        last_grant <= arb_grant;
                        state      <= CMD;
                    end
                end
                CMD: begin
                    tmo_cnt <= '0;
                    if (!host_rd && !host_wr) begin
                        // Host withdrew its request; do not stall on it.
                        state <= IDLE;
                    end else if (!m_waitrequest) begin
                        if (host_wr) begin
                            state <= IDLE;
                        end else if (m_readdatavalid) begin
                            h_readdatavalid[grant] <= 1'b1;
                            h_readdata             <= m_readdata;
                            h_response             <= m_response;
                            state                  <= IDLE;
                        end else begin
                            state <= RDWAIT;
                        end
                    end
                end
                RDWAIT: begin
                    if (m_readdatavalid) begin
                        h_readdatavalid[grant] <= 1'b1;
                        h_readdata             <= m_readdata;
                        h_response             <= m_response;
                        state                  <= IDLE;
                    end else if (tmo_fire) begin
                        h_readdatavalid[grant] <= 1'b1;
                        h_readdata             <= '0;
                        h_response             <= RESP_SLVERR;
                        err_timeout            <= 1'b1;
                        state                  <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_mm_host_arbiter.sv
module tb_avalon_mm_host_arbiter;

    localparam int NH  = 2;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int TMO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NH*AW-1:0]  h_addr;
    logic [NH-1:0]     h_read;
    logic [NH-1:0]     h_write;
    logic [NH*DW-1:0]  h_writedata;
    logic [NH*BW-1:0]  h_byteenable;
    logic [NH-1:0]     h_waitrequest;
    logic [NH-1:0]     h_readdatavalid;
    logic [DW-1:0]     h_readdata;
    logic [1:0]        h_response;
    logic [AW-1:0]     m_addr;
    logic              m_read;
    logic              m_write;
    logic [DW-1:0]     m_writedata;
    logic [BW-1:0]     m_byteenable;
    logic              m_waitrequest;
    logic              m_readdatavalid;
    logic [DW-1:0]     m_readdata;
    logic [1:0]        m_response;
    logic              err_timeout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    avalon_mm_host_arbiter #(
        .NUM_HOSTS      (NH),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .h_addr          (h_addr),
        .h_read          (h_read),
        .h_write         (h_write),
        .h_writedata     (h_writedata),
        .h_byteenable    (h_byteenable),
        .h_waitrequest   (h_waitrequest),
        .h_readdatavalid (h_readdatavalid),
        .h_readdata      (h_readdata),
        .h_response      (h_response),
        .m_addr          (m_addr),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_waitrequest   (m_waitrequest),
        .m_readdatavalid (m_readdatavalid),
        .m_readdata      (m_readdata),
        .m_response      (m_response),
        .err_timeout     (err_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the port, whether a read is in flight,
    // and what the hosts must see on the next cycle.
    int          md_owner = -1;
    bit          md_reading = 1'b0;
    int          md_last = NH - 1;
    int          md_wait = 0;
    int          md_rdv_host = -1;
    bit          md_rdv_err = 1'b0;
    logic [31:0] md_rdv_data = '0;
    logic [1:0]  md_rdv_resp = '0;

    always @(posedge clk or posedge rst) begin : model
        int pick;
        int c;
        if (rst) begin
            md_owner    <= -1;
            md_reading  <= 1'b0;
            md_last     <= NH - 1;
            md_wait     <= 0;
            md_rdv_host <= -1;
            md_rdv_err  <= 1'b0;
        end else begin
            md_rdv_host <= -1;
            md_rdv_err  <= 1'b0;
            if (md_owner < 0) begin
                pick = -1;
                for (int k = 1; k <= NH; k++) begin
                    c = (md_last + k) % NH;
                    if (pick < 0 && (h_read[c] || h_write[c])) pick = c;
                end
                if (pick >= 0) begin
                    md_owner <= pick;
                    md_last  <= pick;
                end
            end else if (!md_reading) begin
                if (!(h_read[md_owner] || h_write[md_owner])) begin
                    md_owner <= -1;
                end else if (!m_waitrequest) begin
                    if (h_write[md_owner]) begin
                        md_owner <= -1;
                    end else if (m_readdatavalid) begin
                        md_rdv_host <= md_owner;
                        md_rdv_data <= m_readdata;
                        md_rdv_resp <= m_response;
                        md_owner    <= -1;
                    end else begin
                        md_reading <= 1'b1;
                        md_wait    <= 0;
                    end
                end
            end else begin
                if (m_readdatavalid) begin
                    md_rdv_host <= md_owner;
                    md_rdv_data <= m_readdata;
                    md_rdv_resp <= m_response;
                    md_owner    <= -1;
                    md_reading  <= 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (md_wait + 1 == TMO) begin
                    md_rdv_host <= md_owner;
                    md_rdv_data <= '0;
                    md_rdv_resp <= 2'b10;
                    md_rdv_err  <= 1'b1;
                    md_owner    <= -1;
                    md_reading  <= 1'b0;
                end
`endif
                else begin
                    md_wait <= md_wait + 1;
                end
            end
        end
    end

    // Observation windows for the directed tests.
    int mw_cnt = 0;
    int mr_cnt = 0;
    int rdv0_cnt = 0;
    int wr1_low_cnt = 0;
    int grants[$];

    always @(negedge clk) begin : compare
        logic [NH-1:0] e_wait;
        logic [NH-1:0] e_rdv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [BW-1:0] e_be;
        logic          e_mr;
        logic          e_mw;
        e_wait = '1;
        e_addr = '0;
        e_wd   = '0;
        e_be   = '0;
        e_mr   = 1'b0;
        e_mw   = 1'b0;
        if (md_owner >= 0 && !md_reading) begin
            e_mw   = h_write[md_owner];
            e_mr   = h_read[md_owner] && !h_write[md_owner];
            e_addr = h_addr[md_owner*AW +: AW];
            e_wd   = h_writedata[md_owner*DW +: DW];
            e_be   = h_byteenable[md_owner*BW +: BW];
            e_wait[md_owner] = m_waitrequest;
        end
        e_rdv = '0;
        if (md_rdv_host >= 0) e_rdv[md_rdv_host] = 1'b1;
        chk("m_write", 32'(m_write), 32'(e_mw));
        chk("m_read", 32'(m_read), 32'(e_mr));
        chk("m_addr", 32'(m_addr), 32'(e_addr));
        chk("m_writedata", m_writedata, e_wd);
        chk("m_byteenable", 32'(m_byteenable), 32'(e_be));
        chk("h_waitrequest", 32'(h_waitrequest), 32'(e_wait));
        chk("h_readdatavalid", 32'(h_readdatavalid), 32'(e_rdv));
        chk("err_timeout", 32'(err_timeout), 32'(md_rdv_err));
        if (md_rdv_host >= 0) begin
            chk("h_readdata", h_readdata, md_rdv_data);
            chk("h_response", 32'(h_response), 32'(md_rdv_resp));
        end
        if (m_write) mw_cnt++;
        if (m_read) mr_cnt++;
        if (h_readdatavalid[0]) rdv0_cnt++;
        if (!h_waitrequest[1]) wr1_low_cnt++;
        if (m_write && !m_waitrequest) begin
            for (int i = 0; i < NH; i++) if (!h_waitrequest[i]) grants.push_back(i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_win();
        mw_cnt = 0;
        mr_cnt = 0;
        rdv0_cnt = 0;
        wr1_low_cnt = 0;
        grants.delete();
    endtask

    initial begin
        rst = 1'b1;
        h_addr = '0;
        h_read = '0;
        h_write = '0;
        h_writedata = '0;
        h_byteenable = '0;
        m_waitrequest = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata = '0;
        m_response = '0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_waitreq", 32'(h_waitrequest), 32'h3);
        chk("rst_rdv", 32'(h_readdatavalid), 32'h0);
        chk("rst_rdata", h_readdata, 32'h0);
        chk("rst_resp", 32'(h_response), 32'h0);
        chk("rst_mcmd", 32'({m_read, m_write}), 32'h0);
        chk("rst_err", 32'(err_timeout), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Single write from host0.
        clr_win();
        h_write = 2'b01;
        h_addr = {4'h0, 4'h8};
        h_writedata = {32'h0, 32'hDEADBEEF};
        h_byteenable = {4'h0, 4'hF};
        @(negedge clk);
        chk("wr_arb_cycle_mwrite", 32'(m_write), 32'h0);
        tick();
        @(negedge clk);
        chk("wr_mwrite", 32'(m_write), 32'h1);
        chk("wr_addr", 32'(m_addr), 32'h8);
        chk("wr_data", m_writedata, 32'hDEADBEEF);
        chk("wr_waitreq", 32'(h_waitrequest), 32'h2);
        tick();
        h_write = 2'b00;
        tick();
        tick();
        chk("wr_mwrite_cycles", 32'(mw_cnt), 32'd1);
        chk("wr_host1_wait_low", 32'(wr1_low_cnt), 32'd0);

        // Read from host1 with 3-cycle downstream latency.
        clr_win();
        h_read = 2'b10;
        h_addr = {4'hC, 4'h0};
        tick();
        @(negedge clk);
        chk("rd_mread", 32'(m_read), 32'h1);
        chk("rd_addr", 32'(m_addr), 32'hC);
        tick();
        h_read = 2'b00;
        tick();
        tick();
        m_readdatavalid = 1'b1;
        m_readdata = 32'h12345678;
        m_response = 2'b00;
        @(negedge clk);
        chk("rd_rdv_early", 32'(h_readdatavalid), 32'h0);
        tick();
        m_readdatavalid = 1'b0;
        m_readdata = 32'h0;
        @(negedge clk);
        chk("rd_rdv", 32'(h_readdatavalid), 32'h2);
        chk("rd_data", h_readdata, 32'h12345678);
        chk("rd_resp", 32'(h_response), 32'h0);
        tick();
        @(negedge clk);
        chk("rd_rdv_one_cycle", 32'(h_readdatavalid), 32'h0);
        tick();
        chk("rd_host0_rdv_never", 32'(rdv0_cnt), 32'd0);

        // Fairness: both hosts keep writing.
        clr_win();
        h_write = 2'b11;
        h_addr = {4'h2, 4'h1};
        h_writedata = {32'h1111B1B1, 32'h0000A0A0};
        h_byteenable = {4'h3, 4'hC};
        for (int i = 0; i < 8; i++) tick();
        h_write = 2'b00;
        tick();
        chk("fair_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("fair_order", (i < grants.size()) ? 32'(grants[i]) : 32'hFF, 32'(i % 2));
        end

        // Zero-latency read behind 2 cycles of backpressure; host1 write queued.
        clr_win();
        h_read = 2'b01;
        h_write = 2'b10;
        h_addr = {4'h6, 4'h4};
        m_waitrequest = 1'b1;
        tick();
        tick();
        tick();
        m_waitrequest = 1'b0;
        m_readdatavalid = 1'b1;
        m_readdata = 32'hCAFEF00D;
        m_response = 2'b11;
        @(negedge clk);
        chk("zl_rdv_early", 32'(h_readdatavalid), 32'h0);
        tick();
        h_read = 2'b00;
        m_readdatavalid = 1'b0;
        @(negedge clk);
        chk("zl_rdv", 32'(h_readdatavalid), 32'h1);
        chk("zl_data", h_readdata, 32'hCAFEF00D);
        chk("zl_resp", 32'(h_response), 32'h3);
        tick();
        @(negedge clk);
        chk("zl_next_grant", 32'({m_write, h_waitrequest}), 32'h5);
        tick();
        h_write = 2'b00;
        tick();
        chk("zl_mread_cycles", 32'(mr_cnt), 32'd3);

        // Reset while a read is outstanding.
        h_read = 2'b10;
        h_addr = {4'hA, 4'h0};
        tick();
        tick();
        h_read = 2'b00;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_waitreq", 32'(h_waitrequest), 32'h3);
        chk("mid_rst_mread", 32'(m_read), 32'h0);
        tick();
        rst = 1'b0;
        m_readdatavalid = 1'b1;
        m_readdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("mid_rst_no_rdv_a", 32'(h_readdatavalid), 32'h0);
        tick();
        m_readdatavalid = 1'b0;
        h_write = 2'b11;
        @(negedge clk);
        chk("mid_rst_no_rdv_b", 32'(h_readdatavalid), 32'h0);
        tick();
        @(negedge clk);
        chk("post_rst_grant0", 32'(h_waitrequest), 32'h2);
        tick();
        h_write = 2'b00;
        tick();
        tick();

        // Read that never gets a response in time.
        h_read = 2'b01;
        h_addr = {4'h0, 4'h3};
        tick();
        tick();
        h_read = 2'b00;
        for (int i = 0; i < 7; i++) tick();
        @(negedge clk);
        chk("tmo_before", 32'({err_timeout, h_readdatavalid}), 32'h0);
        tick();
        m_readdatavalid = 1'b1;
        m_readdata = 32'h55AA55AA;
        m_response = 2'b00;
        @(negedge clk);
`ifdef ARB_TIMEOUT_EN
        chk("tmo_rdv", 32'(h_readdatavalid), 32'h1);
        chk("tmo_resp", 32'(h_response), 32'h2);
        chk("tmo_data", h_readdata, 32'h0);
        chk("tmo_err", 32'(err_timeout), 32'h1);
`else
        chk("notmo_still_waiting", 32'({err_timeout, h_readdatavalid}), 32'h0);
`endif
        tick();
        m_readdatavalid = 1'b0;
        @(negedge clk);
`ifdef ARB_TIMEOUT_EN
        chk("tmo_stray_dropped", 32'(h_readdatavalid), 32'h0);
`else
        chk("notmo_late_rdv", 32'(h_readdatavalid), 32'h1);
        chk("notmo_late_data", h_readdata, 32'h55AA55AA);
`endif
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/avalon_mm_host_arbiter.md
Name: avalon_mm_host_arbiter

Overview:
- Shares the single Avalon-MM slave port of the register manager between NUM_HOSTS Avalon-MM hosts, e.g. the CPU bridge and the DSI init/command sequencer.
- Round-robin grant with one outstanding transaction at a time.
- Forwards the granted host's command downstream, then routes read data and response back to that host only.
- Sits between the host-side interconnect and the register manager inside the DSI controller.

Parameters:
- NUM_HOSTS, 2, number of upstream hosts (2..8).
- ADDR_WIDTH, 4, Avalon byte address width.
- DATA_WIDTH, 32, data width; byteenable width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 64, read-response timeout; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- h_addr  in  NUM_HOSTS*ADDR_WIDTH  per-host address, packed, host i at slice i.
- h_read  in  NUM_HOSTS  per-host read request.
- h_write  in  NUM_HOSTS  per-host write request.
- h_writedata  in  NUM_HOSTS*DATA_WIDTH  per-host write data.
- h_byteenable  in  NUM_HOSTS*DATA_WIDTH/8  per-host byte enables.
- h_waitrequest  out  NUM_HOSTS  per-host waitrequest.
- h_readdatavalid  out  NUM_HOSTS  per-host read-data-valid.
- h_readdata  out  DATA_WIDTH  shared read data; meaningful only with h_readdatavalid.
- h_response  out  2  shared response; meaningful only with h_readdatavalid.
- m_addr, m_read, m_write, m_writedata, m_byteenable  out  downstream command.
- m_waitrequest  in  1  downstream waitrequest.
- m_readdatavalid  in  1  downstream read-data-valid.
- m_readdata  in  DATA_WIDTH  downstream read data.
- m_response  in  2  downstream response.
- err_timeout  out  1  one-cycle pulse on read timeout.

Behaviour:
- Reset values:
  - state IDLE, grant 0, last_grant NUM_HOSTS-1.
  - h_waitrequest all 1; h_readdatavalid 0; h_readdata 0; h_response 0.
  - All m_* outputs 0; err_timeout 0; timeout counter 0.
- States: IDLE, CMD, RDWAIT.
- IDLE:
  - m_read and m_write are 0; all h_waitrequest are 1.
  - A host requests when h_read[i] or h_write[i] is set.
  - Winner is the first requester searching from last_grant+1, wrapping at NUM_HOSTS-1 to 0.
  - Register grant and last_grant, then go to CMD. Arbitration costs one cycle.
  - No requesters: stay in IDLE.
- CMD:
  - m_* outputs are combinationally muxed from host grant.
  - If the granted host asserts both h_read and h_write (illegal), the write wins and the read is ignored.
  - h_waitrequest[grant] = m_waitrequest; all other bits are 1.
  - Write accepted (m_waitrequest=0): go to IDLE.
  - Read accepted:
    - m_readdatavalid also high in the same cycle: capture the response and go to IDLE.
    - Otherwise go to RDWAIT.
- RDWAIT:
  - m_read is 0; all h_waitrequest are 1.
  - On m_readdatavalid: capture m_readdata and m_response, then go to IDLE.
- Read-response timing: h_readdatavalid[grant] is registered. It pulses for exactly one cycle, the cycle after the capture, with h_readdata and h_response held in that cycle.
- m_readdatavalid outside CMD/RDWAIT: ignored; no host sees it.
- Host dropping its request while waitrequest is high: protocol violation. The arbiter mirrors the host's current lines and does not stall.
- Minimum per-transaction latency: grant cycle plus accept cycle, i.e. 2 cycles for a write with zero-wait downstream.
- Reset asserted mid-transaction: immediate return to reset values; the outstanding response is discarded.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in RDWAIT.
  - After TIMEOUT_CYCLES cycles without m_readdatavalid, go to IDLE.
  - Next cycle: h_readdatavalid[grant] pulses with h_readdata=0 and h_response=2'b10 (SLVERR), and err_timeout pulses.
  - A later stray m_readdatavalid is dropped.
- Without the macro: RDWAIT waits indefinitely and err_timeout is tied to 0.

Decomposition:
- Package avalon_arb_pkg holds:
  - state enum arb_state_t {IDLE, CMD, RDWAIT};
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- Sub-module rr_arbiter (parameter N): inputs req[N] and last[$clog2(N)]; outputs grant index and valid. Purely combinational rotate-priority encoder, instantiated once.

Test Plan:
- Single write: host0 writes addr 4'h8, data 32'hDEADBEEF, be 4'hF, m_waitrequest=0. Expect m_write high for exactly 1 cycle with matching addr/data, h_waitrequest[0] low in that cycle, and h_waitrequest[1] held high throughout.
- Fairness: both hosts hold back-to-back writes. Expect downstream grant order 0,1,0,1 over 4 transactions; no host is granted twice in a row while the other requests.
- Read with latency: host1 reads addr 4'hC; downstream returns 32'h12345678 with response 00, 3 cycles after acceptance. Expect h_readdatavalid[1] pulsed one cycle after m_readdatavalid, with correct data, and h_readdatavalid[0] never asserted.
- Zero-latency read plus backpressure: m_waitrequest held high for 2 cycles, then low together with m_readdatavalid. Expect m_read held for 3 cycles and no RDWAIT entry (next grant on the following cycle).
- Reset mid-read: assert rst while in RDWAIT. Expect h_waitrequest all 1, m_read 0, and no h_readdatavalid after reset release. The first post-reset grant goes to host0.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no m_readdatavalid: expect h_response=2'b10, h_readdata=0 and err_timeout pulsed, all 9 cycles after the read is accepted.
